// File: rtl/kyber_usb_pkg.sv
// -----------------------------------------------------------------------------
// kyber_usb_pkg
// Shared constants for the CW305 USB register front end of the Kyber decaps
// core. This package has no ports.
// It provides:
//   - buffer depths (CT_BYTES, SS_BYTES),
//   - address field widths (REG_W, OFS_W),
//   - register indices (REG_ID, REG_STATUS, REG_GO, REG_CT, REG_SS),
//   - the ID byte (ID_VALUE),
//   - the front-end FSM state type.
// Optional feature macro used by the top level: KYBER_TRIG_OUT_EN.
// -----------------------------------------------------------------------------
package kyber_usb_pkg;

    localparam int unsigned CT_BYTES = 768;
    localparam int unsigned SS_BYTES = 32;
    localparam int unsigned REG_W    = 10;
    localparam int unsigned OFS_W    = 10;

    localparam logic [9:0] REG_ID     = 10'd0;
    localparam logic [9:0] REG_STATUS = 10'd4;
    localparam logic [9:0] REG_GO     = 10'd5;
    localparam logic [9:0] REG_CT     = 10'd6;
    localparam logic [9:0] REG_SS     = 10'd7;

    // ASCII 'K': the nominal "KB" tag is not a hex byte.
    localparam logic [7:0] ID_VALUE = 8'h4B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fe_state_e;

endpackage

// File: rtl/kyber_ct_buf.sv
// -----------------------------------------------------------------------------
// kyber_ct_buf
// Ciphertext buffer: simple dual-port byte RAM with registered reads on both
// ports.
// Ports:
//   clk, rst_n              clock, async active-low reset (output registers only)
//   a_we, a_re              port A write / read enable (host side)
//   a_addr, a_wdata         port A address and write byte
//   a_rdata                 port A read byte, 1-cycle latency
//   b_addr                  port B read address (core side)
//   b_rdata                 port B read byte, 1-cycle latency
// Array contents are not reset.
// -----------------------------------------------------------------------------
module kyber_ct_buf #(
    parameter int unsigned DEPTH = 768,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_we,
    input  logic          a_re,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic [7:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Addresses beyond the buffer depth read as zero instead of indexing past the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_re) begin
                a_rdata_q <= (32'(a_addr) < DEPTH) ? mem[a_addr] : '0;
            end
            b_rdata_q <= (32'(b_addr) < DEPTH) ? mem[b_addr] : '0;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/kyber_usb_reg_fe.sv
// -----------------------------------------------------------------------------
// kyber_usb_reg_fe
// Responder for the CW305 USB parallel bus in front of the Kyber decaps core.
//
// Host bus ports:
//   usb_clk, resetn          clock, async active-low reset
//   usb_data (inout 8)       data bus; driven only during a read
//   usb_addr (21)            {1'b0, reg[19:10], ofs[9:0]}
//   usb_rdn, usb_wrn, usb_cen  active-low strobes
//
// Core ports:
//   core_start / core_done   start pulse out, completion pulse in
//   ct_raddr / ct_rdata      core read port into the ciphertext buffer
//   ss_we, ss_waddr, ss_wdata  shared-secret byte writes
//   busy                     high while the core is running
//   trig_out                 only with KYBER_TRIG_OUT_EN: busy delayed one cycle
//
// Registers: 0 ID, 4 STATUS, 5 GO, 6 CT, 7 SS; any other index reads 0.
// -----------------------------------------------------------------------------
module kyber_usb_reg_fe #(
    parameter int unsigned CT_BYTES = kyber_usb_pkg::CT_BYTES,
    parameter int unsigned SS_BYTES = kyber_usb_pkg::SS_BYTES,
    parameter int unsigned REG_W    = kyber_usb_pkg::REG_W,
    parameter int unsigned OFS_W    = kyber_usb_pkg::OFS_W
) (
    input  logic                       usb_clk,
    input  logic                       resetn,
    inout  logic [7:0]                 usb_data,
    input  logic [REG_W+OFS_W:0]       usb_addr,
    input  logic                       usb_rdn,
    input  logic                       usb_wrn,
    input  logic                       usb_cen,
    output logic                       core_start,
    input  logic                       core_done,
    input  logic [OFS_W-1:0]           ct_raddr,
    output logic [7:0]                 ct_rdata,
    input  logic                       ss_we,
    input  logic [$clog2(SS_BYTES)-1:0] ss_waddr,
    input  logic [7:0]                 ss_wdata,
    output logic                       busy
`ifdef KYBER_TRIG_OUT_EN
    ,
    output logic                       trig_out
`endif
);

    import kyber_usb_pkg::*;

    localparam int unsigned SS_AW = $clog2(SS_BYTES);

    // Address decode.
    logic             addr_hi;
    logic [REG_W-1:0] reg_idx;
    logic [OFS_W-1:0] ofs;
    logic             wr_en;
    logic             rd_en;
    logic             go_wr;
    logic             ct_wr;
    logic             ct_in_range;
    logic             ct_we;
    logic             ct_rd;

    assign addr_hi     = usb_addr[REG_W+OFS_W];
    assign reg_idx     = usb_addr[REG_W+OFS_W-1:OFS_W];
    assign ofs         = usb_addr[OFS_W-1:0];
    assign wr_en       = !usb_cen && !usb_wrn;
    // A write takes priority over a read when both strobes are low.
    assign rd_en       = !usb_cen && !usb_rdn && usb_wrn;
    assign go_wr       = wr_en && !addr_hi && (reg_idx == REG_GO);
    assign ct_wr       = wr_en && !addr_hi && (reg_idx == REG_CT);
    assign ct_in_range = 32'(ofs) < CT_BYTES;

    // FSM and its registered outputs.
    fe_state_e state_q;
    logic      core_start_q;
    logic      busy_q;
    logic      done_q;

    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (go_wr) begin
                        state_q      <= ST_RUN;
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (go_wr) begin
                        state_q      <= ST_RUN;
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                    end else if (ct_wr && (ofs == '0)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core_start = core_start_q;
    assign busy       = busy_q;

    // Ciphertext buffer: host writes are locked out while the core runs.
    logic [7:0] ct_a_rdata;

    assign ct_we = ct_wr && ct_in_range && !busy_q;
    assign ct_rd = rd_en && !addr_hi && (reg_idx == REG_CT);

    kyber_ct_buf #(
        .DEPTH (CT_BYTES),
        .AW    (OFS_W)
    ) u_ct_buf (
        .clk     (usb_clk),
        .rst_n   (resetn),
        .a_we    (ct_we),
        .a_re    (ct_rd),
        .a_addr  (ofs),
        .a_wdata (usb_data),
        .a_rdata (ct_a_rdata),
        .b_addr  (ct_raddr),
        .b_rdata (ct_rdata)
    );

    // Shared-secret register file.
    logic [7:0] ss_q [SS_BYTES];

    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < SS_BYTES; i++) begin
                ss_q[i] <= '0;
            end
        end else if (ss_we) begin
            ss_q[ss_waddr] <= ss_wdata;
        end
    end

    // Read path: non-CT bytes are captured here; CT bytes come from the RAM's
    // own output register. ct_sel_q records which one the last read targeted.
    logic [7:0] misc_rdata_d;
    logic [7:0] misc_rdata_q;
    logic       ct_sel_q;

    always_comb begin
        misc_rdata_d = '0;
        if (!addr_hi) begin
            case (reg_idx)
                REG_ID:     misc_rdata_d = ID_VALUE;
                REG_STATUS: misc_rdata_d = {6'b0, done_q, busy_q};
                REG_SS: begin
                    if (ofs[OFS_W-1:SS_AW] == '0) begin
                        misc_rdata_d = ss_q[ofs[SS_AW-1:0]];
                    end
                end
                default: misc_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            misc_rdata_q <= '0;
            ct_sel_q     <= 1'b0;
        end else if (rd_en) begin
            misc_rdata_q <= misc_rdata_d;
            ct_sel_q     <= ct_rd && ct_in_range;
        end
    end

    assign usb_data = rd_en ? (ct_sel_q ? ct_a_rdata : misc_rdata_q) : 'z;

`ifdef KYBER_TRIG_OUT_EN
    logic trig_q;

    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= busy_q;
        end
    end

    assign trig_out = trig_q;
`endif

endmodule

// File: tb/tb_kyber_usb_reg_fe.sv
// -----------------------------------------------------------------------------
// tb_kyber_usb_reg_fe
// Self-checking bench for kyber_usb_reg_fe. The reference model keeps the
// ciphertext and shared-secret bytes in arrays plus two flags (running,
// done). Expected results come from the register map rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_kyber_usb_reg_fe;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [20:0] addr = '0;
    logic        rdn = 1'b1;
    logic        wrn = 1'b1;
    logic        cen = 1'b1;
    logic        host_oe = 1'b0;
    logic [7:0]  host_d = '0;
    wire  [7:0]  usb_data;
    logic        core_start;
    logic        core_done = 1'b0;
    logic [9:0]  ct_raddr = '0;
    logic [7:0]  ct_rdata;
    logic        ss_we = 1'b0;
    logic [4:0]  ss_waddr = '0;
    logic [7:0]  ss_wdata = '0;
    logic        busy;
`ifdef KYBER_TRIG_OUT_EN
    logic        trig_out;
`endif

    assign usb_data = host_oe ? host_d : 8'hzz;

    always #5 clk = ~clk;

    kyber_usb_reg_fe dut (
        .usb_clk    (clk),
        .resetn     (resetn),
        .usb_data   (usb_data),
        .usb_addr   (addr),
        .usb_rdn    (rdn),
        .usb_wrn    (wrn),
        .usb_cen    (cen),
        .core_start (core_start),
        .core_done  (core_done),
        .ct_raddr   (ct_raddr),
        .ct_rdata   (ct_rdata),
        .ss_we      (ss_we),
        .ss_waddr   (ss_waddr),
        .ss_wdata   (ss_wdata),
        .busy       (busy)
`ifdef KYBER_TRIG_OUT_EN
        ,
        .trig_out   (trig_out)
`endif
    );

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    // Reference model state.
    logic [7:0] m_ct [768];
    logic [7:0] m_ss [32];
    bit         m_run = 1'b0;
    bit         m_done = 1'b0;

    logic [9:0] regs [8] = '{10'd0, 10'd1, 10'd4, 10'd5, 10'd6, 10'd7, 10'd9, 10'd1023};

    typedef struct {
        logic [9:0] r;
        logic [9:0] o;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_read(input logic [9:0] r, input logic [9:0] o);
        case (r)
            10'd0:   return 8'h4B;
            10'd4:   return {6'b0, m_done, m_run};
            10'd6:   return (o < 10'd768) ? m_ct[o] : 8'h00;
            10'd7:   return (o < 10'd32) ? m_ss[o[4:0]] : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic host_wr(input logic [9:0] r, input logic [9:0] o, input logic [7:0] d,
                           output bit st);
        st = 1'b0;
        if (r == 10'd5) begin
            if (!m_run) begin
                st = 1'b1;
                m_run = 1'b1;
                m_done = 1'b0;
            end
        end else if (r == 10'd6 && o < 10'd768 && !m_run) begin
            m_ct[o] = d;
            if (o == 10'd0) m_done = 1'b0;
        end
        addr = {1'b0, r, o};
        host_d = d;
        host_oe = 1'b1;
        cen = 1'b0;
        wrn = 1'b0;
        cyc();
        wrn = 1'b1;
        cen = 1'b1;
        host_oe = 1'b0;
    endtask

    task automatic host_rd(input logic [9:0] r, input logic [9:0] o, output logic [7:0] v);
        addr = {1'b0, r, o};
        cen = 1'b0;
        rdn = 1'b0;
        cyc();
        v = usb_data;
        rdn = 1'b1;
        cen = 1'b1;
    endtask

    task automatic pulse_done();
        if (m_run) begin
            m_run = 1'b0;
            m_done = 1'b1;
        end
        core_done = 1'b1;
        cyc();
        core_done = 1'b0;
    endtask

    logic [7:0]  v;
    bit          st;
    int unsigned op;
    logic [9:0]  rr;
    logic [9:0]  oo;
    logic [7:0]  dd;

    initial begin
        vt[0] = '{r: 10'd6, o: 10'd0,   exp: 8'h00, name: "ct_ofs0"};
        vt[1] = '{r: 10'd6, o: 10'd255, exp: 8'hFF, name: "ct_ofs255"};
        vt[2] = '{r: 10'd6, o: 10'd767, exp: 8'hFF, name: "ct_ofs767"};
        vt[3] = '{r: 10'd6, o: 10'd100, exp: 8'h64, name: "ct_ofs100"};
        vt[4] = '{r: 10'd0, o: 10'd0,   exp: 8'h4B, name: "id"};
        vt[5] = '{r: 10'd4, o: 10'd0,   exp: 8'h00, name: "status_idle"};
        vt[6] = '{r: 10'd7, o: 10'd0,   exp: 8'h00, name: "ss_reset"};
        vt[7] = '{r: 10'd7, o: 10'd40,  exp: 8'h00, name: "ss_ofs40"};
        vt[8] = '{r: 10'd3, o: 10'd0,   exp: 8'h00, name: "unmapped"};
        for (int i = 0; i < 32; i++) m_ss[i] = 8'h00;

        // Reset state.
        repeat (3) cyc();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_ct_rdata", 32'(ct_rdata), 32'd0);
`ifdef KYBER_TRIG_OUT_EN
        check("rst_trig", 32'(trig_out), 32'd0);
`endif
        resetn = 1'b1;
        cyc();

        // Back-to-back CT burst with wrn held low.
        cen = 1'b0;
        wrn = 1'b0;
        host_oe = 1'b1;
        for (int i = 0; i < 768; i++) begin
            addr = {1'b0, 10'd6, 10'(i)};
            host_d = 8'(i);
            m_ct[i] = 8'(i);
            cyc();
        end
        wrn = 1'b1;
        cen = 1'b1;
        host_oe = 1'b0;
        cyc();

        for (int i = 0; i < 9; i++) begin
            host_rd(vt[i].r, vt[i].o, v);
            check(vt[i].name, 32'(v), 32'(vt[i].exp));
        end

        // Out-of-range CT write must not wrap onto offset 32.
        host_wr(10'd6, 10'd800, 8'h77, st);
        host_rd(10'd6, 10'd32, v);
        check("ct_no_wrap", 32'(v), 32'h20);

        // Bus released when rdn or cen is high: bench drives 00 and must see 00.
        host_rd(10'd0, 10'd0, v);
        check("id_again", 32'(v), 32'h4B);
        host_d = 8'h00;
        host_oe = 1'b1;
        cen = 1'b0;
        rdn = 1'b1;
        #1;
        check("hiz_rdn", 32'(usb_data), 32'h00);
        cen = 1'b1;
        rdn = 1'b0;
        #1;
        check("hiz_cen", 32'(usb_data), 32'h00);
        rdn = 1'b1;
        host_oe = 1'b0;

        // Core read port latency.
        ct_raddr = 10'd5;
        cyc();
        check("ct_portb", 32'(ct_rdata), 32'h05);

        // GO: single start pulse, busy, trigger lag.
        host_wr(10'd5, 10'd0, 8'h01, st);
        check("go_start", 32'(core_start), 32'(st));
        check("go_busy", 32'(busy), 32'd1);
`ifdef KYBER_TRIG_OUT_EN
        check("trig_lag0", 32'(trig_out), 32'd0);
`endif
        cyc();
        check("go_start_end", 32'(core_start), 32'd0);
`ifdef KYBER_TRIG_OUT_EN
        check("trig_rise", 32'(trig_out), 32'd1);
`endif
        host_rd(10'd4, 10'd0, v);
        check("status_run", 32'(v), 32'h01);
        host_wr(10'd5, 10'd0, 8'h01, st);
        check("go_in_run", 32'(core_start), 32'd0);

        // CT write during RUN is dropped.
        host_wr(10'd6, 10'd3, 8'hAA, st);
        ct_raddr = 10'd3;
        cyc();
        check("ct_run_locked", 32'(ct_rdata), 32'h03);

        // Core fills the shared secret and finishes.
        for (int i = 0; i < 32; i++) begin
            ss_we = 1'b1;
            ss_waddr = 5'(i);
            ss_wdata = 8'hC0 + 8'(i);
            m_ss[i] = 8'hC0 + 8'(i);
            cyc();
        end
        ss_we = 1'b0;
        pulse_done();
        check("done_busy", 32'(busy), 32'd0);
`ifdef KYBER_TRIG_OUT_EN
        check("trig_hold", 32'(trig_out), 32'd1);
        cyc();
        check("trig_fall", 32'(trig_out), 32'd0);
`endif
        host_rd(10'd4, 10'd0, v);
        check("status_done", 32'(v), 32'h02);

        // Same-cycle host read and core write of one SS byte returns the old byte.
        addr = {1'b0, 10'd7, 10'd10};
        cen = 1'b0;
        rdn = 1'b0;
        ss_we = 1'b1;
        ss_waddr = 5'd10;
        ss_wdata = 8'h11;
        cyc();
        check("ss_collide", 32'(usb_data), 32'hCA);
        ss_we = 1'b0;
        rdn = 1'b1;
        cen = 1'b1;
        m_ss[10] = 8'h11;
        for (int i = 0; i < 32; i++) begin
            host_rd(10'd7, 10'(i), v);
            check("ss_read", 32'(v), 32'(m_ss[i]));
        end
        host_rd(10'd7, 10'd40, v);
        check("ss_ofs40_done", 32'(v), 32'h00);

        // DONE -> RUN, then reset mid-RUN.
        host_wr(10'd5, 10'd0, 8'h00, st);
        check("go_from_done", 32'(core_start), 32'd1);
        #2;
        resetn = 1'b0;
        m_run = 1'b0;
        m_done = 1'b0;
        for (int i = 0; i < 32; i++) m_ss[i] = 8'h00;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_start", 32'(core_start), 32'd0);
        cyc();
        resetn = 1'b1;
        cyc();
        host_rd(10'd4, 10'd0, v);
        check("rst_mid_status", 32'(v), 32'h00);
        pulse_done();
        host_rd(10'd4, 10'd0, v);
        check("late_done_ignored", 32'(v), 32'h00);
        host_rd(10'd7, 10'd0, v);
        check("ss_cleared", 32'(v), 32'h00);
        host_rd(10'd6, 10'd1, v);
        check("ct_kept", 32'(v), 32'h01);

        // DONE -> IDLE on CT offset 0 write.
        host_wr(10'd5, 10'd0, 8'h00, st);
        check("go2_start", 32'(core_start), 32'd1);
        pulse_done();
        host_rd(10'd4, 10'd0, v);
        check("status_done2", 32'(v), 32'h02);
        host_wr(10'd6, 10'd0, 8'h5C, st);
        host_rd(10'd4, 10'd0, v);
        check("status_after_ct0", 32'(v), 32'h00);
        host_rd(10'd6, 10'd0, v);
        check("ct0_written", 32'(v), 32'h5C);

        // Write wins over read when both strobes are low.
        addr = {1'b0, 10'd6, 10'd50};
        host_d = 8'h33;
        host_oe = 1'b1;
        cen = 1'b0;
        wrn = 1'b0;
        rdn = 1'b0;
        #1;
        check("wr_prio_bus", 32'(usb_data), 32'h33);
        cyc();
        wrn = 1'b1;
        rdn = 1'b1;
        cen = 1'b1;
        host_oe = 1'b0;
        m_ct[50] = 8'h33;
        host_rd(10'd6, 10'd50, v);
        check("wr_prio_data", 32'(v), 32'h33);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 9);
            rr = regs[$urandom_range(0, 7)];
            dd = 8'($urandom);
            if (op <= 2) begin
                oo = (rr == 10'd6) ? 10'($urandom_range(0, 767)) : 10'($urandom_range(0, 1023));
                host_rd(rr, oo, v);
                check("rnd_read", 32'(v), 32'(m_read(rr, oo)));
            end else if (op <= 4 || op == 7) begin
                if (op == 7) rr = 10'd5;
                oo = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
                host_wr(rr, oo, dd, st);
                check("rnd_start", 32'(core_start), 32'(st));
                check("rnd_busy", 32'(busy), 32'(m_run));
            end else if (op == 5) begin
                ss_we = 1'b1;
                ss_waddr = 5'($urandom_range(0, 31));
                ss_wdata = dd;
                m_ss[ss_waddr] = dd;
                cyc();
                ss_we = 1'b0;
            end else if (op == 6) begin
                pulse_done();
                check("rnd_done_busy", 32'(busy), 32'(m_run));
            end else begin
                ct_raddr = 10'($urandom_range(0, 767));
                cyc();
                check("rnd_portb", 32'(ct_rdata), 32'(m_ct[ct_raddr]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
